memory_bus_master: RTL and testbench

//  Initiator side of the shared Select/RW/DataBus memory interface; the Memory block is the responder.

---
 rtl/memory_bus_master_pkg.sv | 20 ++
 rtl/memory_bus_master_wait_counter.sv | 29 ++
 rtl/memory_bus_master.sv | 103 ++++++++++
 tb/tb_memory_bus_master.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_bus_master_pkg.sv
// Shared definitions for the memory bus master: bus direction codes,
// FSM state encodings and the wait-counter width helper.
package memory_bus_master_pkg;

  // Bus direction as seen on RW
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // FSM state encodings (2-bit, legacy-compatible)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_TURN   = 2'd3;

  // Counter width able to hold WAIT_CYCLES-1; never narrower than one bit
  function automatic int wait_cnt_width(input int wait_cycles);
    return (wait_cycles < 2) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/memory_bus_master_wait_counter.sv
// Down-counter that times the ACCESS phase of a bus cycle.
// Loaded on entry to ACCESS, decremented each ACCESS cycle, flags zero.
module bus_wait_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  // Load has priority; decrement saturates at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/memory_bus_master.sv
// Initiator side of the Select/RW/DataBus memory interface.
// Accepts one request at a time from a valid/ready client port, runs a
// SETUP / ACCESS(xWAIT_CYCLES) [/ TURN for writes] bus cycle and returns
// a single response pulse with read data or echoed write data.
module memory_bus_master
  import memory_bus_master_pkg::*;
#(
  parameter int N           = 8,
  parameter int M           = 3,
  parameter int WAIT_CYCLES = 1
) (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic         ReqValid,
  output logic         ReqReady,
  input  logic         ReqWrite,
  input  logic [M-1:0] ReqAddr,
  input  logic [N-1:0] ReqData,
  output logic         RspValid,
  output logic [N-1:0] RspData,
  output logic         Busy,
  output logic [M-1:0] Select,
  output logic         RW,
  inout  wire  [N-1:0] DataBus
);

  localparam int CW = wait_cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);

  logic [1:0]   state_reg, state_next;
  logic [M-1:0] select_reg;
  logic [N-1:0] data_reg;
  logic         write_reg;
  logic         rw_reg, rw_next;
  logic         rsp_valid_reg;
  logic [N-1:0] rsp_data_reg;
  logic         accept;
  logic         access_done;
  logic         cnt_zero;

  assign accept      = (state_reg == ST_IDLE) && ReqValid;
  assign access_done = (state_reg == ST_ACCESS) && cnt_zero;

  bus_wait_counter #(
    .WIDTH(CW)
  ) u_wait_counter (
    .clk       (Clock),
    .rst_n     (ResetN),
    .load      (state_reg == ST_SETUP),
    .load_value(WAIT_LOAD),
    .dec       (state_reg == ST_ACCESS),
    .zero      (cnt_zero)
  );

  // Next-state logic; RW is derived from the next state so it is registered
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (ReqValid) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (cnt_zero) state_next = write_reg ? ST_TURN : ST_IDLE;
      ST_TURN:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    rw_next = ((state_next == ST_ACCESS) && write_reg) ? RW_WRITE : RW_READ;
  end

  // FSM, request latch, bus outputs and response register
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_reg     <= ST_IDLE;
      select_reg    <= '0;
      data_reg      <= '0;
      write_reg     <= 1'b0;
      rw_reg        <= RW_READ;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      rw_reg        <= rw_next;
      rsp_valid_reg <= access_done;
      if (accept) begin
        select_reg <= ReqAddr;
        data_reg   <= ReqData;
        write_reg  <= ReqWrite;
      end
      if (access_done) begin
        rsp_data_reg <= write_reg ? data_reg : DataBus;
      end
    end
  end

  assign ReqReady = (state_reg == ST_IDLE);
  assign Busy     = (state_reg != ST_IDLE);
  assign Select   = select_reg;
  assign RW       = rw_reg;
  assign RspValid = rsp_valid_reg;
  assign RspData  = rsp_data_reg;

  // Drive the shared bus only while the registered direction says write
  assign DataBus = (rw_reg == RW_WRITE) ? data_reg : {N{1'bz}};

endmodule

// File: tb/tb_memory_bus_master.sv
// Bench for memory_bus_master: two masters (WAIT_CYCLES=1 and 3), each on
// its own behavioural memory responder, checked against a transaction-level
// reference model (expected data from a model array, expected latency 2+W).
module tb_memory_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n     [2];
  logic       req_valid [2];
  logic       req_write [2];
  logic [2:0] req_addr  [2];
  logic [7:0] req_data  [2];
  logic       req_ready [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_data  [2];
  logic       busy      [2];
  logic [2:0] sel       [2];
  logic       rw        [2];
  wire  [7:0] bus0;
  wire  [7:0] bus1;

  logic [7:0] mem0 [8];
  logic [7:0] mem1 [8];
  logic       mem_clr;
  logic [7:0] mdl  [2][8];
  logic       mon_en = 1'b0;
  int         errors = 0;
  int         checks = 0;
  int         mon_prints = 0;

  memory_bus_master #(.N(8), .M(3), .WAIT_CYCLES(1)) u_dut_w1 (
    .Clock(clk), .ResetN(rst_n[0]), .ReqValid(req_valid[0]), .ReqReady(req_ready[0]),
    .ReqWrite(req_write[0]), .ReqAddr(req_addr[0]), .ReqData(req_data[0]),
    .RspValid(rsp_valid[0]), .RspData(rsp_data[0]), .Busy(busy[0]),
    .Select(sel[0]), .RW(rw[0]), .DataBus(bus0)
  );

  memory_bus_master #(.N(8), .M(3), .WAIT_CYCLES(3)) u_dut_w3 (
    .Clock(clk), .ResetN(rst_n[1]), .ReqValid(req_valid[1]), .ReqReady(req_ready[1]),
    .ReqWrite(req_write[1]), .ReqAddr(req_addr[1]), .ReqData(req_data[1]),
    .RspValid(rsp_valid[1]), .RspData(rsp_data[1]), .Busy(busy[1]),
    .Select(sel[1]), .RW(rw[1]), .DataBus(bus1)
  );

  // Memory responders: drive the bus whenever RW=0, store on edges with RW=1
  assign bus0 = (rw[0] == 1'b0) ? mem0[sel[0]] : 8'bz;
  assign bus1 = (rw[1] == 1'b0) ? mem1[sel[1]] : 8'bz;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
    end else begin
      if (rw[0] === 1'b1) mem0[sel[0]] <= bus0;
      if (rw[1] === 1'b1) mem1[sel[1]] <= bus1;
    end
  end

  function automatic logic [7:0] bus_of(input int d);
    return (d == 0) ? bus0 : bus1;
  endfunction

  function automatic logic [7:0] mem_at(input int d, input logic [2:0] a);
    return (d == 0) ? mem0[a] : mem1[a];
  endfunction

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Continuous bus-protocol monitor
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (rw[d] === 1'b0 && bus_of(d) !== mem_at(d, sel[d])) begin
          errors++;
          if (mon_prints < 10) $display("FAIL bus_release d=%0d got=%h want=%h", d, bus_of(d), mem_at(d, sel[d]));
          mon_prints++;
        end else if (rw[d] === 1'b1 && (busy[d] !== 1'b1 || $isunknown(bus_of(d)))) begin
          errors++;
          if (mon_prints < 10) $display("FAIL rw_outside_busy d=%0d busy=%b bus=%h", d, busy[d], bus_of(d));
          mon_prints++;
        end else if (req_ready[d] !== ~busy[d]) begin
          errors++;
          if (mon_prints < 10) $display("FAIL ready_vs_busy d=%0d ready=%b busy=%b", d, req_ready[d], busy[d]);
          mon_prints++;
        end
      end
    end
  end

  // One complete transaction on master d, checked against the model
  task automatic txn(input int d, input bit wr, input logic [2:0] a, input logic [7:0] wd, input bit hold);
    int w = wait_of(d);
    int guard = 0;
    int cyc;
    int rw_cnt = 0;
    int sel_bad = 0;
    int early_ready = 0;
    bit got = 0;
    bit ready_at_rsp;
    logic [7:0] exp;
    while (req_ready[d] !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (req_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait d=%0d got=%b want=1", d, req_ready[d]);
      return;
    end
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_data[d]  = wd;
    exp = wr ? wd : mdl[d][a];
    if (wr) mdl[d][a] = wd;
    @(negedge clk);
    cyc = 1;
    if (!hold) req_valid[d] = 1'b0;
    while (cyc <= 12) begin
      if (rw[d] === 1'b1) rw_cnt++;
      if (sel[d] !== a) sel_bad++;
      if (rsp_valid[d] === 1'b1) begin
        got = 1;
        break;
      end
      if (req_ready[d] !== 1'b0) early_ready++;
      if (hold) begin
        req_addr[d]  = 3'($urandom_range(7));
        req_data[d]  = 8'($urandom_range(255));
        req_write[d] = 1'($urandom_range(1));
      end
      @(negedge clk);
      cyc++;
    end
    req_valid[d] = 1'b0;
    ready_at_rsp = req_ready[d];
    $display("txn d=%0d %s addr=%0d data=%h rsp=%h lat=%0d", d, wr ? "WR" : "RD", a, exp, rsp_data[d], cyc);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rsp_timeout d=%0d got=none want=cycle %0d", d, 2 + w);
      return;
    end
    checks++;
    if (cyc != 2 + w) begin
      errors++;
      $display("FAIL latency d=%0d got=%0d want=%0d", d, cyc, 2 + w);
    end
    checks++;
    if (rsp_data[d] !== exp) begin
      errors++;
      $display("FAIL rsp_data d=%0d addr=%0d got=%h want=%h", d, a, rsp_data[d], exp);
    end
    checks++;
    if (rw_cnt != (wr ? w : 0)) begin
      errors++;
      $display("FAIL rw_cycles d=%0d got=%0d want=%0d", d, rw_cnt, wr ? w : 0);
    end
    checks++;
    if (sel_bad != 0) begin
      errors++;
      $display("FAIL select_stable d=%0d got=%0d bad cycles want=0", d, sel_bad);
    end
    checks++;
    if (early_ready != 0) begin
      errors++;
      $display("FAIL ready_while_busy d=%0d got=%0d cycles want=0", d, early_ready);
    end
    if (!wr) begin
      checks++;
      if (ready_at_rsp !== 1'b1) begin
        errors++;
        $display("FAIL ready_at_rsp d=%0d got=%b want=1", d, ready_at_rsp);
      end
    end
    @(negedge clk);
    checks++;
    if (rsp_valid[d] !== 1'b0 || rsp_data[d] !== exp) begin
      errors++;
      $display("FAIL rsp_pulse_hold d=%0d got=%b/%h want=0/%h", d, rsp_valid[d], rsp_data[d], exp);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_addr[d] = '0;
      req_data[d] = '0;
      for (int i = 0; i < 8; i++) mdl[d][i] = '0;
    end
    mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_clr = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1 || busy[d] !== 1'b0 || rw[d] !== 1'b0 || sel[d] !== 3'd0 ||
          rsp_valid[d] !== 1'b0 || rsp_data[d] !== 8'h00 || bus_of(d) !== 8'h00) begin
        errors++;
        $display("FAIL reset_state d=%0d got rdy=%b busy=%b rw=%b sel=%0d rv=%b rd=%h bus=%h want 1 0 0 0 0 00 00",
                 d, req_ready[d], busy[d], rw[d], sel[d], rsp_valid[d], rsp_data[d], bus_of(d));
      end
      rst_n[d] = 1'b1;
    end
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_all();
    for (int a = 0; a < 8; a++) txn(0, 1'b0, 3'(a), 8'h00, 1'b0);
  endtask

  task automatic test_write_read();
    txn(0, 1'b1, 3'd0, 8'd74, 1'b0);
    txn(0, 1'b0, 3'd0, 8'h00, 1'b0);
    txn(0, 1'b0, 3'd1, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int d = 0; d < 2; d++) begin
      txn(d, 1'b1, 3'd5, 8'hAA, 1'b0);
      txn(d, 1'b0, 3'd5, 8'h00, 1'b0);
      txn(d, 1'b1, 3'd7, 8'h3C, 1'b0);
      txn(d, 1'b0, 3'd7, 8'h00, 1'b0);
    end
  endtask

  task automatic test_reset_during_write();
    int late_rsp = 0;
    txn(0, 1'b1, 3'd0, 8'hA3, 1'b0);
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 3'd6;
    req_data[0]  = 8'h5C;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (rw[0] !== 1'b1) begin
      errors++;
      $display("FAIL write_access_rw got=%b want=1", rw[0]);
    end
    rst_n[0] = 1'b0;
    #1;
    checks++;
    if (rw[0] !== 1'b0 || sel[0] !== 3'd0 || busy[0] !== 1'b0 || rsp_valid[0] !== 1'b0 || bus0 !== 8'hA3) begin
      errors++;
      $display("FAIL async_reset got rw=%b sel=%0d busy=%b rv=%b bus=%h want 0 0 0 0 a3",
               rw[0], sel[0], busy[0], rsp_valid[0], bus0);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid[0] !== 1'b0) late_rsp++;
    end
    checks++;
    if (late_rsp != 0) begin
      errors++;
      $display("FAIL dropped_rsp got=%0d pulses want=0", late_rsp);
    end
    checks++;
    if (mem0[6] !== mdl[0][6]) begin
      errors++;
      $display("FAIL mem_not_written got=%h want=%h", mem0[6], mdl[0][6]);
    end
    txn(0, 1'b0, 3'd6, 8'h00, 1'b0);
  endtask

  task automatic test_wait3();
    txn(1, 1'b0, 3'd0, 8'h00, 1'b0);
    txn(1, 1'b1, 3'd2, 8'h81, 1'b0);
    txn(1, 1'b0, 3'd2, 8'h00, 1'b0);
  endtask

  task automatic test_hold_ignored();
    for (int d = 0; d < 2; d++) begin
      txn(d, 1'b1, 3'd3, 8'h96, 1'b1);
      txn(d, 1'b0, 3'd3, 8'h00, 1'b1);
      txn(d, 1'b0, 3'd4, 8'h00, 1'b1);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      txn(k % 2, 1'($urandom_range(1)), 3'($urandom_range(7)), 8'($urandom_range(255)), 1'($urandom_range(1)));
    end
  endtask

  initial begin
    test_reset();
    test_read_all();
    test_write_read();
    test_back_to_back();
    test_reset_during_write();
    test_wait3();
    test_hold_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
